mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore FSM control unit for the multi-cycle MIPS datapath.
- Sequences the shared ALU, PC/IR registers, register file and unified memory across FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives every datapath mux select (2:1 and 4:1), write strobe and ALU control.
- Supports a memory-ready handshake so memory latency is variable.

Parameters:
- OP_W, 6, opcode field width (instr[31:26]).
- FN_W, 6, funct field width (instr[5:0]).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  OP_W  opcode from IR.
- funct  in  FN_W  funct from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register-file write strobe.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = regA.
- alu_src_b  out  2  ALU B select: 00 = regB, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  out  4  current state encoding, for debug.
- illegal_op  out  1  unsupported instruction seen in DECODE.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.

Behaviour:
- State register: 4-bit. Asynchronously cleared to FETCH(0) on rst_n=0.
- While rst_n=0, all strobes (pc_write, ir_write, mem_write, reg_write, instr_done, illegal_op) are forced to 0. All other outputs take their FETCH values.
- Outputs are a combinational decode of state. Exceptions: gating by mem_ready/zero, and illegal_op.
- Any output not listed for a state is 0, with alu_control=010.

States (encoding, outputs -> next):
- FETCH(0): alu_src_b=01, ir_write=pc_write=mem_ready. Stay until mem_ready=1, then DECODE.
- DECODE(1): alu_src_b=11. Next state by op:
  - 100011 lw, 101011 sw -> MEMADR
  - 000000 R -> EXECUTE
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - Any other op, or an R-type funct outside {100000, 100010, 100100, 100101, 101010}: illegal_op=1 this cycle, next FETCH, no strobes.
- MEMADR(2): alu_src_a=1, alu_src_b=10. lw -> MEMRD, sw -> MEMWR.
- MEMRD(3): i_or_d=1. Stay until mem_ready, then MEMWB.
- MEMWB(4): mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
- MEMWR(5): i_or_d=1, mem_write=1, held every cycle until mem_ready. instr_done=mem_ready. Exit to FETCH on mem_ready.
- EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_control from funct: add 010, sub 110, and 000, or 001, slt 111 -> ALUWB.
- ALUWB(7): reg_dst=1, reg_write=1, instr_done=1 -> FETCH.
- BRANCH(8): alu_src_a=1, alu_control=110, pc_src=01, pc_write=zero, instr_done=1 -> FETCH.
- ADDIEX(9): alu_src_a=1, alu_src_b=10 -> ADDIWB.
- ADDIWB(10): reg_write=1, instr_done=1 -> FETCH.
- JUMP(11): pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- Unused encodings (12-15): all outputs 0, next FETCH.

Latency (mem_ready tied 1), in cycles:
- lw 5; sw 4; R 4; addi 4; beq 3; j 3.
- Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.

Other rules:
- rst_n asserted mid-instruction aborts immediately: no strobe is asserted after the reset edge.

Optional Feature:
- Macro BNE_SUPPORT_EN.
- Defined: op 000101 (bne) decodes to BRANCH, with pc_write=~zero for bne (zero for beq). Op is sampled from IR, which is stable during BRANCH.
- Undefined: 000101 is illegal (illegal_op=1 in DECODE, next FETCH).

Test Plan:
- rst_n=0 mid-MEMWR with mem_write=1 -> mem_write drops immediately. After release, state=0, pc_write=ir_write=1 with mem_ready=1.
- lw (op=100011), mem_ready=1 -> states 0,1,2,3,4. reg_write=1 and mem_to_reg=1 only in state 4; instr_done in state 4.
- R-type sub (funct=100010) -> alu_control=110 in EXECUTE; ALUWB has reg_dst=1, reg_write=1. Total 4 cycles.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles, single instr_done on the accepting cycle.
- beq, zero=0 -> pc_write=0 in BRANCH. Same with zero=1 -> pc_write=1, pc_src=01.
- op=111111 -> illegal_op=1 in DECODE, next state 0, no reg_write/mem_write. With BNE_SUPPORT_EN, op=000101 and zero=0 -> pc_write=1 in BRANCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore-style control unit for the multi-cycle MIPS datapath. Steps the
//   shared ALU, PC/IR, register file and unified memory through
//   FETCH/DECODE/EXECUTE/MEM/WB states, driving every mux select, write
//   strobe and ALU control code.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   op, funct         opcode and funct fields taken from the IR
//   zero              ALU zero flag (branch condition)
//   mem_ready         memory completes the current access this cycle
//   pc_write, ir_write, mem_write, reg_write   write strobes
//   i_or_d, reg_dst, mem_to_reg, alu_src_a     2:1 mux selects
//   alu_src_b, pc_src                          4:1 mux selects
//   alu_control       ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   state             current state encoding, for debug
//   illegal_op        unsupported instruction seen in DECODE
//   instr_done        one-cycle pulse on the final cycle of each instruction
//
// Configuration
//   BNE_SUPPORT_EN    when defined, bne (000101) is decoded and branches on
//                     ~zero; otherwise bne is treated as an illegal opcode.

module mips_multicycle_ctrl #(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic [FN_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            mem_write,
  output logic            reg_write,
  output logic            i_or_d,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_src,
  output logic [2:0]      alu_control,
  output logic [3:0]      state,
  output logic            illegal_op,
  output logic            instr_done
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef BNE_SUPPORT_EN
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

  localparam logic [FN_W-1:0] FN_ADD = FN_W'(6'b100000);
  localparam logic [FN_W-1:0] FN_SUB = FN_W'(6'b100010);
  localparam logic [FN_W-1:0] FN_AND = FN_W'(6'b100100);
  localparam logic [FN_W-1:0] FN_OR  = FN_W'(6'b100101);
  localparam logic [FN_W-1:0] FN_SLT = FN_W'(6'b101010);

  state_e state_q, state_d;
  logic   op_legal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; op_legal is the DECODE-time legality check, shared
  // with the output process so illegal_op and the FETCH fallback agree.
  always_comb begin
    state_d  = FETCH;
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW: op_legal = 1'b1;
      OP_BEQ:       op_legal = 1'b1;
      OP_ADDI:      op_legal = 1'b1;
      OP_J:         op_legal = 1'b1;
`ifdef BNE_SUPPORT_EN
      OP_BNE:       op_legal = 1'b1;
`endif
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: op_legal = 1'b1;
          default:                               op_legal = 1'b0;
        endcase
      end
      default: op_legal = 1'b0;
    endcase

    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (!op_legal)                      state_d = FETCH;
        else if (op == OP_LW || op == OP_SW) state_d = MEMADR;
        else if (op == OP_RTYPE)            state_d = EXECUTE;
        else if (op == OP_ADDI)             state_d = ADDIEX;
        else if (op == OP_J)                state_d = JUMP;
        else                                state_d = BRANCH;
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode of the current state. Strobes are additionally gated by
  // rst_n so nothing is written while reset is held, even in FETCH where
  // the PC/IR strobes follow mem_ready.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b010;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !op_legal;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:   i_or_d = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_control = 3'b110;
          FN_AND:  alu_control = 3'b000;
          FN_OR:   alu_control = 3'b001;
          FN_SLT:  alu_control = 3'b111;
          default: alu_control = 3'b010;
        endcase
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        pc_src      = 2'b01;
        instr_done  = 1'b1;
`ifdef BNE_SUPPORT_EN
        // IR is held through BRANCH, so op still identifies beq vs bne.
        pc_write    = (op == OP_BNE) ? ~zero : zero;
`else
        pc_write    = zero;
`endif
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: alu_control = 3'b000;
    endcase

    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed bench for mips_multicycle_ctrl. Each stimulus cycle pushes the
//   hand-derived expected output vector into a scoreboard queue; a monitor
//   pops and compares on every falling edge while entries are pending.

module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       iord;
    logic       rdst;
    logic       m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       ill;
    logic       done;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } sb_item_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_write, reg_write;
  logic       i_or_d, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic       illegal_op, instr_done;

  sb_item_t sb[$];
  int total = 0;
  int bad   = 0;

  mips_multicycle_ctrl #(.OP_W(6), .FN_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .i_or_d     (i_or_d),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_control(alu_control),
    .state      (state),
    .illegal_op (illegal_op),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e      = '0;
    e.st   = st;
    e.aluc = 3'b010;
    return e;
  endfunction

  function automatic exp_t fetchExp(input logic mr);
    exp_t e;
    e      = base(4'd0);
    e.srcb = 2'b01;
    e.pcw  = mr;
    e.irw  = mr;
    return e;
  endfunction

  function automatic exp_t decodeExp(input logic ill);
    exp_t e;
    e      = base(4'd1);
    e.srcb = 2'b11;
    e.ill  = ill;
    return e;
  endfunction

  // Reset view: FETCH selects with every strobe held low.
  function automatic exp_t resetExp();
    exp_t e;
    e      = base(4'd0);
    e.srcb = 2'b01;
    return e;
  endfunction

  task automatic checkOutput(input sb_item_t it);
    exp_t act;
    act = '{st: state, pcw: pc_write, irw: ir_write, mw: mem_write,
            rw: reg_write, iord: i_or_d, rdst: reg_dst, m2r: mem_to_reg,
            srca: alu_src_a, srcb: alu_src_b, pcsrc: pc_src,
            aluc: alu_control, ill: illegal_op, done: instr_done};
    total++;
    if (act !== it.e) begin
      bad++;
      $display("[TB] FAIL %s: got %b required %b (st=%0d vs %0d)",
               it.name, act, it.e, act.st, it.e.st);
    end
  endtask

  // Drive one cycle of inputs (phase: just after a rising edge), queue the
  // expected outputs for that cycle, then advance to the next edge.
  task automatic applyStimulus(input string name, input logic [5:0] o,
                               input logic [5:0] f, input logic z,
                               input logic mr, input exp_t e);
    sb_item_t it;
    op        = o;
    funct     = f;
    zero      = z;
    mem_ready = mr;
    it.e      = e;
    it.name   = name;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    op        = '0;
    funct     = '0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("reset_hold", 6'b0, 6'b0, 1'b0, 1'b1, resetExp());
    rst_n = 1'b1;

    // lw, mem_ready high: 0,1,2,3,4
    applyStimulus("lw_fetch", 6'b100011, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("lw_decode", 6'b100011, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
    applyStimulus("lw_memadr", 6'b100011, 6'b0, 1'b0, 1'b1, e);
    e = base(4'd3); e.iord = 1'b1;
    applyStimulus("lw_memrd", 6'b100011, 6'b0, 1'b0, 1'b1, e);
    e = base(4'd4); e.m2r = 1'b1; e.rw = 1'b1; e.done = 1'b1;
    applyStimulus("lw_memwb", 6'b100011, 6'b0, 1'b0, 1'b1, e);

    // lw with one wait cycle in MEMRD
    applyStimulus("lw2_fetch", 6'b100011, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("lw2_decode", 6'b100011, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
    applyStimulus("lw2_memadr", 6'b100011, 6'b0, 1'b0, 1'b1, e);
    e = base(4'd3); e.iord = 1'b1;
    applyStimulus("lw2_memrd_wait", 6'b100011, 6'b0, 1'b0, 1'b0, e);
    applyStimulus("lw2_memrd_go", 6'b100011, 6'b0, 1'b0, 1'b1, e);
    e = base(4'd4); e.m2r = 1'b1; e.rw = 1'b1; e.done = 1'b1;
    applyStimulus("lw2_memwb", 6'b100011, 6'b0, 1'b0, 1'b1, e);

    // R-type sub, preceded by one FETCH wait
    applyStimulus("sub_fetch_wait", 6'b0, 6'b100010, 1'b0, 1'b0, fetchExp(1'b0));
    applyStimulus("sub_fetch", 6'b0, 6'b100010, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("sub_decode", 6'b0, 6'b100010, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd6); e.srca = 1'b1; e.srcb = 2'b00; e.aluc = 3'b110;
    applyStimulus("sub_execute", 6'b0, 6'b100010, 1'b0, 1'b1, e);
    e = base(4'd7); e.rdst = 1'b1; e.rw = 1'b1; e.done = 1'b1;
    applyStimulus("sub_aluwb", 6'b0, 6'b100010, 1'b0, 1'b1, e);

    // R-type slt and or: check the funct-to-ALU mapping
    applyStimulus("slt_fetch", 6'b0, 6'b101010, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("slt_decode", 6'b0, 6'b101010, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd6); e.srca = 1'b1; e.aluc = 3'b111;
    applyStimulus("slt_execute", 6'b0, 6'b101010, 1'b0, 1'b1, e);
    e = base(4'd7); e.rdst = 1'b1; e.rw = 1'b1; e.done = 1'b1;
    applyStimulus("slt_aluwb", 6'b0, 6'b101010, 1'b0, 1'b1, e);
    applyStimulus("or_fetch", 6'b0, 6'b100101, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("or_decode", 6'b0, 6'b100101, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd6); e.srca = 1'b1; e.aluc = 3'b001;
    applyStimulus("or_execute", 6'b0, 6'b100101, 1'b0, 1'b1, e);
    e = base(4'd7); e.rdst = 1'b1; e.rw = 1'b1; e.done = 1'b1;
    applyStimulus("or_aluwb", 6'b0, 6'b100101, 1'b0, 1'b1, e);

    // sw with mem_ready low for 3 cycles in MEMWR
    applyStimulus("sw_fetch", 6'b101011, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("sw_decode", 6'b101011, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
    applyStimulus("sw_memadr", 6'b101011, 6'b0, 1'b0, 1'b1, e);
    e = base(4'd5); e.iord = 1'b1; e.mw = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus("sw_memwr_wait", 6'b101011, 6'b0, 1'b0, 1'b0, e);
    e.done = 1'b1;
    applyStimulus("sw_memwr_go", 6'b101011, 6'b0, 1'b0, 1'b1, e);

    // beq not taken, then taken
    applyStimulus("beq0_fetch", 6'b000100, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("beq0_decode", 6'b000100, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd8); e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.done = 1'b1;
    applyStimulus("beq0_branch", 6'b000100, 6'b0, 1'b0, 1'b1, e);
    applyStimulus("beq1_fetch", 6'b000100, 6'b0, 1'b1, 1'b1, fetchExp(1'b1));
    applyStimulus("beq1_decode", 6'b000100, 6'b0, 1'b1, 1'b1, decodeExp(1'b0));
    e.pcw = 1'b1;
    applyStimulus("beq1_branch", 6'b000100, 6'b0, 1'b1, 1'b1, e);

    // addi
    applyStimulus("addi_fetch", 6'b001000, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("addi_decode", 6'b001000, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd9); e.srca = 1'b1; e.srcb = 2'b10;
    applyStimulus("addi_ex", 6'b001000, 6'b0, 1'b0, 1'b1, e);
    e = base(4'd10); e.rw = 1'b1; e.done = 1'b1;
    applyStimulus("addi_wb", 6'b001000, 6'b0, 1'b0, 1'b1, e);

    // j
    applyStimulus("j_fetch", 6'b000010, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("j_decode", 6'b000010, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd11); e.pcsrc = 2'b10; e.pcw = 1'b1; e.done = 1'b1;
    applyStimulus("j_jump", 6'b000010, 6'b0, 1'b0, 1'b1, e);

    // illegal opcode and illegal R-type funct fall back to FETCH
    applyStimulus("ill_fetch", 6'b111111, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("ill_decode", 6'b111111, 6'b0, 1'b0, 1'b1, decodeExp(1'b1));
    applyStimulus("illfn_fetch", 6'b0, 6'b000000, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("illfn_decode", 6'b0, 6'b000000, 1'b0, 1'b1, decodeExp(1'b1));

    // bne with zero=0
    applyStimulus("bne_fetch", 6'b000101, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
`ifdef BNE_SUPPORT_EN
    applyStimulus("bne_decode", 6'b000101, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd8); e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
    e.done = 1'b1; e.pcw = 1'b1;
    applyStimulus("bne_branch", 6'b000101, 6'b0, 1'b0, 1'b1, e);
`else
    applyStimulus("bne_decode_ill", 6'b000101, 6'b0, 1'b0, 1'b1, decodeExp(1'b1));
`endif

    // reset asserted mid-MEMWR
    applyStimulus("rst_fetch", 6'b101011, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("rst_decode", 6'b101011, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
    applyStimulus("rst_memadr", 6'b101011, 6'b0, 1'b0, 1'b1, e);
    e = base(4'd5); e.iord = 1'b1; e.mw = 1'b1;
    applyStimulus("rst_memwr", 6'b101011, 6'b0, 1'b0, 1'b0, e);
    rst_n = 1'b0;
    applyStimulus("rst_abort", 6'b101011, 6'b0, 1'b0, 1'b1, resetExp());
    rst_n = 1'b1;
    applyStimulus("rst_release_fetch", 6'b000010, 6'b0, 1'b0, 1'b1, fetchExp(1'b1));
    applyStimulus("rst_j_decode", 6'b000010, 6'b0, 1'b0, 1'b1, decodeExp(1'b0));
    e = base(4'd11); e.pcsrc = 2'b10; e.pcw = 1'b1; e.done = 1'b1;
    applyStimulus("rst_j_jump", 6'b000010, 6'b0, 1'b0, 1'b1, e);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending entries required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
